// File: rtl/tcb_gpio_wr_arb_if.sv
// Requester and downstream write-channel bundle for tcb_gpio_wr_arb.
// slave = arbiter view, master = view of whatever drives the requesters and downstream ready.
interface tcb_gpio_wr_arb_if #(
    parameter int N  = 2,
    parameter int GW = 32
);
    logic [N-1:0]       req_vld;
    logic [N-1:0][3:0]  req_adr;
    logic [N-1:0][31:0] req_wdt;
    logic [N-1:0][31:0] req_msk;
    logic [N-1:0]       req_rdy;
    logic [N-1:0]       req_err;
    logic               man_vld;
    logic [3:0]         man_adr;
    logic [31:0]        man_wdt;
    logic               man_rdy;
    logic [GW-1:0]      sh_o;
    logic [GW-1:0]      sh_e;

    modport master (
        output req_vld, req_adr, req_wdt, req_msk, man_rdy,
        input  req_rdy, req_err, man_vld, man_adr, man_wdt, sh_o, sh_e
    );

    modport slave (
        input  req_vld, req_adr, req_wdt, req_msk, man_rdy,
        output req_rdy, req_err, man_vld, man_adr, man_wdt, sh_o, sh_e
    );
endinterface

// File: rtl/tcb_gpio_wr_arb.sv
// Round-robin write arbiter for a GPIO controller with shadowed read-modify-write merge.
// Optional macro TCB_GPIO_ARB_OWN_EN restricts each requester's mask to its OWN bits.
module tcb_gpio_wr_arb #(
    parameter int                 N   = 2,
    parameter int                 GW  = 32,
    parameter logic [N-1:0][31:0] OWN = '1
) (
    input  logic             clk,
    input  logic             rst,
    tcb_gpio_wr_arb_if.slave bus
);
    localparam int          PW    = $clog2(N);
    localparam logic [31:0] GMASK = (GW >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << GW) - 64'd1);
`ifdef TCB_GPIO_ARB_OWN_EN
    localparam bit OWN_ON = 1'b1;
`else
    localparam bit OWN_ON = 1'b0;
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] sho_q, sho_d, she_q, she_d;
    logic [3:0]    adr_q, adr_d;
    logic [31:0]   wdt_q, wdt_d;
    logic [N-1:0]  err_q, err_d;
    logic [N-1:0]  rdy;

    logic          accept;
    logic          found;
    logic [PW-1:0] win;
    logic [PW:0]   pick;
    logic          legal;
    logic [3:0]    w_adr;
    logic [31:0]   msk_eff, base, merged;

    // First valid requester at or after ptr, wrapping; returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] vld, input logic [PW-1:0] ptr);
        logic [PW:0]   r;
        logic [PW-1:0] j;
        int            idx;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            j = PW'(idx);
            if (vld[j]) r = {1'b1, j};
        end
        return r;
    endfunction

    function automatic logic [31:0] widen(input logic [GW-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GW-1:0] = v;
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sho_d   = sho_q;
        she_d   = she_q;
        adr_d   = adr_q;
        wdt_d   = wdt_q;
        err_d   = '0;
        rdy     = '0;

        accept  = (state_q == IDLE) || bus.man_rdy;
        pick    = rr_pick(bus.req_vld, ptr_q);
        found   = pick[PW];
        win     = pick[PW-1:0];
        w_adr   = bus.req_adr[win];
        legal   = (w_adr == 4'h0) || (w_adr == 4'h4);
        msk_eff = bus.req_msk[win] & (OWN_ON ? OWN[win] : 32'hFFFF_FFFF);
        base    = w_adr[2] ? widen(she_q) : widen(sho_q);
        merged  = ((base & ~msk_eff) | (bus.req_wdt[win] & msk_eff)) & GMASK;

        // A held BUSY beat only frees up when downstream takes it; an accept with no legal winner idles.
        if (accept) begin
            state_d = IDLE;
            if (found && !rst) begin
                rdy[win] = 1'b1;
                ptr_d    = (win == PW'(N - 1)) ? '0 : win + 1'b1;
                if (legal) begin
                    if (w_adr[2]) she_d = merged[GW-1:0];
                    else          sho_d = merged[GW-1:0];
                    adr_d   = w_adr;
                    wdt_d   = merged;
                    state_d = BUSY;
                end else begin
                    err_d[win] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sho_q   <= '0;
            she_q   <= '0;
            adr_q   <= '0;
            wdt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sho_q   <= sho_d;
            she_q   <= she_d;
            adr_q   <= adr_d;
            wdt_q   <= wdt_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_rdy = rdy;
    assign bus.req_err = err_q;
    assign bus.man_vld = (state_q == BUSY);
    assign bus.man_adr = adr_q;
    assign bus.man_wdt = wdt_q;
    assign bus.sh_o    = sho_q;
    assign bus.sh_e    = she_q;
endmodule

// File: doc/tcb_gpio_wr_arb.md
Name: tcb_gpio_wr_arb

Overview:
- Write-channel arbiter that shares one GPIO controller write port between N independent requesters.
- Each requester writes only the bits it selects with a per-bit mask. The arbiter keeps shadow copies of the GPIO output and output-enable registers and performs the read-modify-write merge itself, so requesters never clobber each other's bits.
- Sits between software/hardware agents (CPU, PWM, bit-bang engines) and the GPIO controller write channel, which has response delay 0.

Parameters:
- N, 2, number of requesters (2..8)
- GW, 32, GPIO width (1..32); bits above GW are forced to 0 on the downstream write data
- OWN, all-ones per requester, N x 32-bit ownership masks (used only with the optional feature)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_vld  input  N  request valid, one per requester
- req_adr  input  N x 4  register address: 0x0 = output, 0x4 = enable
- req_wdt  input  N x 32  write data
- req_msk  input  N x 32  bit write mask (1 = update bit)
- req_rdy  output  N  request accepted (one-hot or zero)
- req_err  output  N  one-cycle pulse: accepted request had an illegal address
- man_vld  output  1  downstream write valid
- man_adr  output  4  downstream address
- man_wdt  output  32  downstream write data (merged full register)
- man_rdy  input  1  downstream ready
- sh_o  output  GW  shadow of the GPIO output register
- sh_e  output  GW  shadow of the GPIO output-enable register

Behaviour:
- Clocking and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - man_vld=0, man_adr=0, man_wdt=0.
  - sh_o=0, sh_e=0 (these match the GPIO controller reset values).
  - Round-robin pointer=0; req_rdy=0, req_err=0; FSM=IDLE.
- FSM has two states:
  - IDLE: man_vld=0.
  - BUSY: man_vld=1 and man_adr/man_wdt held stable until man_rdy=1.
- Accept condition: accept = (IDLE) or (BUSY and man_rdy). Back-to-back transfers with no bubble are required.
- Arbitration (combinational):
  - Round-robin over the req_vld bits, starting at the pointer.
  - The winner gets req_rdy=1 in the same cycle only when accept is true. A requester sees a transfer when req_vld & req_rdy.
  - After granting requester i, the pointer becomes (i+1) mod N.
- Merge rule:
  - m = req_msk.
  - adr 0x0: new = (sh_o & ~m) | (req_wdt & m).
  - adr 0x4: same formula on sh_e.
  - The shadow updates in the acceptance cycle. man_adr/man_wdt register the new value, man_vld=1 the next cycle, FSM→BUSY.
  - Latency from request accept to man_vld is 1 cycle.
- Illegal address (any adr other than 0x0/0x4):
  - Accepted (req_rdy=1), no downstream transfer, shadows unchanged.
  - req_err pulses for one cycle on the following cycle for that requester.
  - The pointer still advances.
- Leaving BUSY: on man_rdy with no new legal accepted request → IDLE, man_vld=0.
- Multiple writes to the same register:
  - Serialized. Each merge uses the shadow already updated by the previous accepted write, so no bit update is lost.
  - The downstream sequence order equals the grant order.
- Zero mask (msk=0) still produces a downstream write of the unchanged value.
- Reset asserted mid-BUSY: man_vld drops to 0 on the next edge and the pending write is discarded. The GPIO controller is reset by the same rst, so the shadows stay coherent.
- req_vld is not required to be held by a requester. A requester that drops req_vld before grant simply loses its turn.

Optional Feature:
- Macro: TCB_GPIO_ARB_OWN_EN.
- Defined:
  - Effective mask = req_msk[i] & OWN[i].
  - Writes to non-owned bits are silently ignored (still accepted, no req_err).
- Undefined:
  - OWN is ignored; effective mask = req_msk[i].

Test Plan:
- Single write: r0 adr=0x0, wdt=0xFFFF_FFFF, msk=0x0000_00FF → req_rdy[0]=1; next cycle man_vld=1, man_adr=0x0, man_wdt=0x0000_00FF, sh_o=0x0000_00FF.
- Contention: r0 and r1 both request adr=0x0; r0 msk=0x0F, wdt=0x05; r1 msk=0xF0, wdt=0x30; pointer=0 → r0 granted first, r1 next cycle; man_wdt sequence 0x05 then 0x35.
- Backpressure: man_rdy=0 for 3 cycles with a write pending → man_vld/man_adr/man_wdt stable and req_rdy=0 for all requesters; man_rdy=1 → the next write issues with no bubble.
- Illegal address: r1 adr=0x8 → req_rdy[1]=1, req_err[1] pulses once, man_vld stays 0, sh_o/sh_e unchanged.
- Reset: rst asserted while BUSY with man_wdt=0xA5 → next cycle man_vld=0, sh_o=0, sh_e=0, pointer=0.
- With TCB_GPIO_ARB_OWN_EN, OWN[0]=0x0000_000F: r0 adr=0x4, msk=0xFF, wdt=0xFF → man_wdt=0x0000_000F, sh_e=0x0F.
